// File: rtl/alu_pkg.sv
// Shared ALU definitions: the shifter datapath width, the result-stage flag
// bundle and the state encoding of the shifter's output stage.
package alu_pkg;

    localparam int LSR_WIDTH   = 32;
    localparam int LSR_SHIFT_W = $clog2(LSR_WIDTH);

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic err;
    } lsr_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/lsr_flag_gen.sv
// Combinational Z/N/C flags and a shift-consistency check for one
// logical-shift-right result.
module lsr_flag_gen
    import alu_pkg::*;
#(
    parameter int  WIDTH = LSR_WIDTH,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] rin,
    input  logic [SHW-1:0]   n,
    input  logic [WIDTH-1:0] rx,
    output lsr_flags_t       flags
);

    logic [SHW-1:0] n_m1;

    assign n_m1 = n - SHW'(1);

    // Carry is the last bit pushed out; a zero shift pushes nothing out.
    always_comb begin
        flags.z   = (rx == '0);
        flags.n   = rx[WIDTH-1];
        flags.c   = (n != '0) ? rin[n_m1] : 1'b0;
        flags.err = (rx != (rin >> n));
    end

endmodule

// File: rtl/lsr_result_stage.sv
// Registered output stage behind the LSR shifter: flags, consistency check,
// handshaked output and a wrapping transfer counter.
// Define LSR_RESULT_STAGE_SKID_EN for the two-entry skid version with a
// registered in_ready; otherwise in_ready is combinational from out_ready.
module lsr_result_stage
    import alu_pkg::*;
#(
    parameter int  WIDTH = LSR_WIDTH,
    parameter int  CNT_W = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rin,
    input  logic [SHW-1:0]   in_n,
    input  logic [WIDTH-1:0] in_rx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rx,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    lsr_flags_t       in_flags;
    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_rx_q, main_rx_d;
    lsr_flags_t       main_flags_q, main_flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire;
    logic             out_fire;
`ifdef LSR_RESULT_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_rx_q, skid_rx_d;
    lsr_flags_t       skid_flags_q, skid_flags_d;
    logic             in_ready_q, in_ready_d;
`endif

    lsr_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .rin   (in_rin),
        .n     (in_n),
        .rx    (in_rx),
        .flags (in_flags)
    );

    assign out_valid = (state_q != EMPTY);
`ifdef LSR_RESULT_STAGE_SKID_EN
    assign in_ready  = in_ready_q;
`else
    assign in_ready  = !out_valid || out_ready;
`endif
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_rx    = main_rx_q;
    assign out_z     = main_flags_q.z;
    assign out_n     = main_flags_q.n;
    assign out_c     = main_flags_q.c;
    assign out_err   = main_flags_q.err;
    assign xfer_cnt  = cnt_q;

    always_comb begin
        state_d      = state_q;
        main_rx_d    = main_rx_q;
        main_flags_d = main_flags_q;
        cnt_d        = cnt_q;
`ifdef LSR_RESULT_STAGE_SKID_EN
        skid_rx_d    = skid_rx_q;
        skid_flags_d = skid_flags_q;
`endif
        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_rx_d    = in_rx;
                    main_flags_d = in_flags;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_rx_d    = in_rx;
                    main_flags_d = in_flags;
`ifdef LSR_RESULT_STAGE_SKID_EN
                end else if (in_fire) begin
                    // Consumer stalled: park the new entry behind the main one.
                    skid_rx_d    = in_rx;
                    skid_flags_d = in_flags;
                    state_d      = FULL;
`endif
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
`ifdef LSR_RESULT_STAGE_SKID_EN
            FULL: begin
                if (out_fire) begin
                    main_rx_d    = skid_rx_q;
                    main_flags_d = skid_flags_q;
                    state_d      = ONE;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
`ifdef LSR_RESULT_STAGE_SKID_EN
        in_ready_d = (state_d != FULL);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_rx_q    <= '0;
            main_flags_q <= '0;
            cnt_q        <= '0;
`ifdef LSR_RESULT_STAGE_SKID_EN
            skid_rx_q    <= '0;
            skid_flags_q <= '0;
            in_ready_q   <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            main_rx_q    <= main_rx_d;
            main_flags_q <= main_flags_d;
            cnt_q        <= cnt_d;
`ifdef LSR_RESULT_STAGE_SKID_EN
            skid_rx_q    <= skid_rx_d;
            skid_flags_q <= skid_flags_d;
            in_ready_q   <= in_ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsr_result_stage.sv
// Scoreboard bench for lsr_result_stage: directed cases plus randomized traffic
// checked against an arithmetic reference model of the shift rules.
module tb_lsr_result_stage;

    localparam int CNT_W = 4;
`ifdef LSR_RESULT_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [31:0] rx;
        logic        z;
        logic        n;
        logic        c;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_rin;
    logic [4:0]       in_n;
    logic [31:0]      in_rx;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_rx;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_err;
    logic [CNT_W-1:0] xfer_cnt;

    exp_t sb[$];
    int   cnt_model = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    lsr_result_stage #(.WIDTH(32), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rin    (in_rin),
        .in_n      (in_n),
        .in_rx     (in_rx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rx    (out_rx),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_c     (out_c),
        .out_err   (out_err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Shift rules expressed as division by powers of two.
    function automatic exp_t refModel(input logic [31:0] rin, input logic [4:0] n, input logic [31:0] rx);
        exp_t        r;
        logic [31:0] pw;
        logic [31:0] quotient;
        pw       = 32'd1 << n;
        quotient = rin / pw;
        r.rx     = rx;
        r.z      = (rx == 32'd0);
        r.n      = (rx >= 32'h8000_0000);
        r.c      = (n == 5'd0) ? 1'b0 : (((rin / (pw / 32'd2)) % 32'd2) == 32'd1);
        r.err    = (rx != quotient);
        return r;
    endfunction

    // Monitor: checks handshake signals every cycle, pops on output transfers
    // and pushes on input transfers, both completing at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            cnt_model = 0;
        end else begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
`ifdef LSR_RESULT_STAGE_SKID_EN
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < CAP});
`else
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() == 0) || out_ready});
`endif
            checkOutput("xfer_cnt", {28'd0, xfer_cnt}, cnt_model);
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("out_rx", out_rx, e.rx);
                checkOutput("out_z", {31'd0, out_z}, {31'd0, e.z});
                checkOutput("out_n", {31'd0, out_n}, {31'd0, e.n});
                checkOutput("out_c", {31'd0, out_c}, {31'd0, e.c});
                checkOutput("out_err", {31'd0, out_err}, {31'd0, e.err});
                cnt_model = (cnt_model + 1) % (1 << CNT_W);
            end
            if (in_valid && in_ready) begin
                sb.push_back(refModel(in_rin, in_n, in_rx));
            end
        end
    end

    // Offers one input and returns 1 time unit after the edge that accepts it.
    task automatic applyStimulus(input logic [31:0] rin, input logic [4:0] n, input logic [31:0] rx);
        logic accepted;
        in_rin   = rin;
        in_n     = n;
        in_rx    = rx;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_rx", out_rx, 32'd0);
        checkOutput("rst_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'd0);
        checkOutput("rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
    endtask

    task automatic randomWord(output logic [31:0] rin, output logic [4:0] n, output logic [31:0] rx);
        rin = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom;
        n   = 5'($urandom_range(0, 31));
        rx  = rin >> n;
        if ($urandom_range(0, 3) == 0) rx = rx ^ (32'd1 << $urandom_range(0, 31));
    endtask

    initial begin
        logic [31:0] r_rin;
        logic [4:0]  r_n;
        logic [31:0] r_rx;
        logic [31:0] held;

        rst = 1'b1;
        in_valid = 1'b0;
        in_rin = '0;
        in_n = '0;
        in_rx = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState();

        out_ready = 1'b1;
        applyStimulus(32'd924385, 5'd5, 32'd28887);
        checkOutput("t1_rx", out_rx, 32'd28887);
        checkOutput("t1_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t1_cnt", {28'd0, xfer_cnt}, 32'd1);

        applyStimulus(32'd3, 5'd1, 32'd1);
        checkOutput("b2b1_cz", {30'd0, out_c, out_z}, 32'd2);
        applyStimulus(32'd1, 5'd1, 32'd0);
        checkOutput("b2b2_cz", {30'd0, out_c, out_z}, 32'd3);

        applyStimulus(32'h8000_0000, 5'd25, 32'd64);
        checkOutput("msb_ce", {30'd0, out_c, out_err}, 32'd0);
        applyStimulus(32'd15, 5'd0, 32'd15);
        checkOutput("n0_ce", {30'd0, out_c, out_err}, 32'd0);
        applyStimulus(32'h8000_0000, 5'd25, 32'd65);
        checkOutput("corrupt_err", {31'd0, out_err}, 32'd1);
        applyStimulus(32'h4000_0001, 5'd31, 32'd0);
        checkOutput("n31_c", {31'd0, out_c}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: fill the stage, then offer one more while stalled.
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            randomWord(r_rin, r_n, r_rx);
            applyStimulus(r_rin, r_n, r_rx);
        end
        held = out_rx;
        @(negedge clk);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        randomWord(r_rin, r_n, r_rx);
        in_rin = r_rin;
        in_n = r_n;
        in_rx = r_rx;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_rx", out_rx, held);
        out_ready = 1'b1;
        applyStimulus(r_rin, r_n, r_rx);
        repeat (4) @(posedge clk);
        #1;

        // Counter wrap with a 4-bit counter.
        doReset();
        for (int i = 0; i < 17; i++) begin
            randomWord(r_rin, r_n, r_rx);
            applyStimulus(r_rin, r_n, r_rx);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap_cnt", {28'd0, xfer_cnt}, 32'd1);

        // Reset while holding entries, with an input offered on the same edge.
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            randomWord(r_rin, r_n, r_rx);
            applyStimulus(r_rin, r_n, r_rx);
        end
        randomWord(r_rin, r_n, r_rx);
        in_rin = r_rin | 32'd1;
        in_n = r_n;
        in_rx = r_rx;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checkResetState();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            randomWord(r_rin, r_n, r_rx);
            in_rin = r_rin;
            in_n = r_n;
            in_rx = r_rx;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drain_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/lsr_result_stage.md
# lsr_result_stage

Registered output stage directly downstream of the 32-bit logical-shift-right datapath in the ALU. It accepts the shifter's operand, shift amount and result over a valid/ready handshake. It derives the Z/N/C flags and a data-consistency check, and presents them with the result to the writeback side through a registered, backpressure-capable output. It also keeps a wrapping count of completed transfers for debug.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; shift-amount width is `$clog2(WIDTH)` (5 at default).
- `CNT_W`, 16: width of the transfer counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  shifter result present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rin`  in  WIDTH  unshifted operand fed to the shifter.
- `in_n`  in  5  shift amount, 0..31.
- `in_rx`  in  WIDTH  shifter result.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_rx`  out  WIDTH  registered result.
- `out_z`  out  1  result == 0.
- `out_n`  out  1  result MSB.
- `out_c`  out  1  last bit shifted out: `in_rin[in_n-1]` if `in_n != 0`, else 0.
- `out_err`  out  1  `in_rx != (in_rin >> in_n)` at capture.
- `xfer_cnt`  out  CNT_W  number of output handshakes completed, wraps.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Flags and err are computed combinationally from the input fields. They are stored alongside `in_rx` as one entry.
- Storage has two entries: a main output register and a skid register.
- States:
  - EMPTY: `out_valid=0`.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- EMPTY + input → ONE.
- ONE + input + no output → FULL; the incoming entry goes to skid.
- ONE + input + output → ONE; main reloads from input.
- ONE + output only → EMPTY.
- FULL + output → ONE; main takes the skid entry, and the skid register frees.
- `in_ready = (state != FULL)`, driven directly from a register with no combinational path from `out_ready`.
- Input data is ignored when `in_valid=0`. Output fields hold their value while `out_valid && !out_ready`.
- `xfer_cnt` increments by 1 per output transfer. It wraps from `2^CNT_W-1` to 0.
- `in_n == 0`: `out_c=0`, result equals operand.
- `in_n == 31`: `out_c = in_rin[30]`.

## Timing
- Latency is 1 cycle: an input accepted at edge k appears on `out_*` after edge k with `out_valid=1`.
- Throughput is 1 transfer per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `in_ready=1`, `out_rx=0`, `out_z=0`, `out_n=0`, `out_c=0`, `out_err=0`, `xfer_cnt=0`. The FSM goes to EMPTY.
- Reset asserted mid-stream discards both entries on that edge. Inputs presented in the same cycle are not captured.
- Simultaneous input and output in FULL cannot occur, because `in_ready=0` in that state.

## Configuration
- `LSR_RESULT_STAGE_SKID_EN`:
  - Defined: two-entry behaviour as above, with `in_ready` registered.
  - Undefined: the skid register and FULL state are removed. `in_ready = !out_valid || out_ready`, which is combinational from `out_ready`. Latency, flags and counter behaviour are unchanged.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` and shift-width constants.
  - Flag struct typedef `lsr_flags_t` {z, n, c, err}.
  - Stage-state enum {EMPTY, ONE, FULL}.
- One natural sub-module, `lsr_flag_gen`: combinational flag and check logic from (rin, n, rx).
- Registers, FSM and counter live in the top module.

## Test plan
- `rin=924385`, `n=5`, `rx=28887`, `out_ready=1` → next cycle `out_rx=28887`, z=0, n=0, c=0, err=0, `xfer_cnt=1`.
- `rin=3`, `n=1`, `rx=1`, then `rin=1`, `n=1`, `rx=0` back to back → c=1, z=0; then c=1, z=1. One result per cycle.
- `rin=32'h8000_0000`, `n=25`, `rx=64`; then `rin=15`, `n=0`, `rx=15` → c=0/err=0 for both. A corrupted `rx=65` → `out_err=1`.
- Hold `out_ready=0` and push 3 inputs → two accepted, `in_ready=0` after the second. Release → outputs appear in order, no loss or duplication.
- Force `xfer_cnt` near wrap with `CNT_W=4` and complete 17 transfers → `xfer_cnt=1`.
- Assert `rst` while FULL → next cycle `out_valid=0`, `in_ready=1`, `xfer_cnt=0`, all outputs 0.
